// File: rtl/udp_csum_zero_pkg.sv
// Shared definitions for the UDP checksum-zeroing stage.
// Byte k of a 256-bit beat sits at tdata[255-8k -: 8]; the MSB constants
// below are the top bit of each header field within its beat.
package udp_csum_zero_pkg;

  typedef enum logic [1:0] {
    HDR1    = 2'b00,
    HDR2    = 2'b01,
    PAYLOAD = 2'b10
  } state_t;

  localparam logic [15:0] ETH_IPV4      = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL5 = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

  // Beat 1 fields
  localparam int unsigned ETHERTYPE_MSB = 159;  // bytes 12-13
  localparam int unsigned VER_IHL_MSB   = 143;  // byte 14
  localparam int unsigned FRAG_MSB      = 95;   // bytes 20-21 (flags + offset)
  localparam int unsigned PROTO_MSB     = 71;   // byte 23

  // Beat 2 fields
  localparam int unsigned UDP_CSUM_MSB     = 191;  // bytes 8-9
  localparam int unsigned UDP_CSUM_STRB_HI = 23;   // strobe of byte 8
  localparam int unsigned UDP_CSUM_STRB_LO = 22;   // strobe of byte 9

  localparam logic [31:0] DEFAULT_CTRL = 32'h0000_0001;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream register slice.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_s_*, o_s_tready       upstream beat and ready
//   o_m_*, i_m_tready       registered downstream beat and ready
// Upstream ready is high whenever the register is empty or being drained,
// so back-to-back beats flow with no bubbles.
module axis_reg_slice #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned USER_WIDTH = 128
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DATA_WIDTH-1:0]   i_s_tdata,
  input  logic [DATA_WIDTH/8-1:0] i_s_tstrb,
  input  logic [USER_WIDTH-1:0]   i_s_tuser,
  input  logic                    i_s_tlast,
  input  logic                    i_s_tvalid,
  output logic                    o_s_tready,
  output logic [DATA_WIDTH-1:0]   o_m_tdata,
  output logic [DATA_WIDTH/8-1:0] o_m_tstrb,
  output logic [USER_WIDTH-1:0]   o_m_tuser,
  output logic                    o_m_tlast,
  output logic                    o_m_tvalid,
  input  logic                    i_m_tready
);

  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_tdata;
  logic [DATA_WIDTH/8-1:0] r_tstrb;
  logic [USER_WIDTH-1:0]   r_tuser;
  logic                    r_tlast;

  assign o_s_tready = !r_valid || i_m_tready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_tdata <= '0;
      r_tstrb <= '0;
      r_tuser <= '0;
      r_tlast <= 1'b0;
    end else if (i_s_tvalid && o_s_tready) begin
      r_valid <= 1'b1;
      r_tdata <= i_s_tdata;
      r_tstrb <= i_s_tstrb;
      r_tuser <= i_s_tuser;
      r_tlast <= i_s_tlast;
    end else if (i_m_tready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_m_tvalid = r_valid;
  assign o_m_tdata  = r_tdata;
  assign o_m_tstrb  = r_tstrb;
  assign o_m_tuser  = r_tuser;
  assign o_m_tlast  = r_tlast;

endmodule

// File: rtl/udp_csum_zero.sv
// UDP checksum-zeroing stage, placed after the crypto stage (which scrambles
// bytes from offset 34 on and so invalidates UDP checksums).
// IPv4/UDP packets that are not fragments get their UDP checksum cleared to
// 0x0000 on beat 2; all other traffic passes unchanged. One register slice.
// Ports:
//   axi_aclk, axi_aresetn   clock, asynchronous active-low reset
//   s_axis_*                upstream AXI-Stream (tuser passed through)
//   m_axis_*                downstream AXI-Stream
//   rw_regs                 bit0 enable, bit1 counter clear (level)
//   rw_defaults             reset value of rw_regs
//   ro_regs                 {pkts_bypassed, pkts_zeroed, pkts_total}
module udp_csum_zero
  import udp_csum_zero_pkg::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
  parameter int unsigned NUM_RW_REGS          = 1,
  parameter int unsigned NUM_RO_REGS          = 3
) (
  input  logic                                        axi_aclk,
  input  logic                                        axi_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]            s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]             s_axis_tuser,
  input  logic                                        s_axis_tvalid,
  output logic                                        s_axis_tready,
  input  logic                                        s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic                                        m_axis_tlast,
  input  logic [C_S_AXI_DATA_WIDTH*NUM_RW_REGS-1:0]   rw_regs,
  output logic [C_S_AXI_DATA_WIDTH*NUM_RW_REGS-1:0]   rw_defaults,
  output logic [C_S_AXI_DATA_WIDTH*NUM_RO_REGS-1:0]   ro_regs
);

  state_t                           r_state;
  logic                             r_match_q;
  logic                             r_patched;
  logic [31:0]                      r_pkts_total;
  logic [31:0]                      r_pkts_zeroed;
  logic [31:0]                      r_pkts_bypassed;

  logic                             w_enable;
  logic                             w_clear;
  logic                             w_unused_ctrl;
  logic                             w_accept;
  logic                             w_match;
  logic                             w_csum_strb;
  logic                             w_patch;
  logic                             w_count_zeroed;
  logic [C_S_AXIS_DATA_WIDTH-1:0]   w_tdata;

  assign w_enable      = rw_regs[0];
  assign w_clear       = rw_regs[1];
  assign w_unused_ctrl = ^rw_regs[C_S_AXI_DATA_WIDTH*NUM_RW_REGS-1:2];
  assign rw_defaults   = DEFAULT_CTRL;

  assign w_accept = s_axis_tvalid && s_axis_tready;

  // Flags (top 3 bits of bytes 20-21) are ignored; only a non-zero fragment
  // offset disqualifies, since later fragments carry no UDP header.
  assign w_match = (s_axis_tdata[ETHERTYPE_MSB -: 16] == ETH_IPV4)
                && (s_axis_tdata[VER_IHL_MSB -: 8] == IPV4_VER_IHL5)
                && (s_axis_tdata[FRAG_MSB-3 -: 13] == '0)
                && (s_axis_tdata[PROTO_MSB -: 8] == IP_PROTO_UDP);

  assign w_csum_strb = s_axis_tstrb[UDP_CSUM_STRB_HI] && s_axis_tstrb[UDP_CSUM_STRB_LO];
  assign w_patch     = (r_state == HDR2) && r_match_q && w_enable && w_csum_strb;

  always_comb begin
    w_tdata = s_axis_tdata;
    if (w_patch) w_tdata[UDP_CSUM_MSB -: 16] = '0;
  end

  // A packet ending on beat 2 uses this beat's patch decision; a longer one
  // uses the decision remembered from its beat 2.
  assign w_count_zeroed = ((r_state == HDR2) && w_patch)
                       || ((r_state == PAYLOAD) && r_patched);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state   <= HDR1;
      r_match_q <= 1'b0;
      r_patched <= 1'b0;
    end else if (w_accept) begin
      case (r_state)
        HDR1: begin
          r_match_q <= w_match;
          r_state   <= s_axis_tlast ? HDR1 : HDR2;
        end
        HDR2: begin
          r_patched <= w_patch;
          r_state   <= s_axis_tlast ? HDR1 : PAYLOAD;
        end
        PAYLOAD: begin
          if (s_axis_tlast) r_state <= HDR1;
        end
        default: r_state <= HDR1;
      endcase
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_pkts_total    <= '0;
      r_pkts_zeroed   <= '0;
      r_pkts_bypassed <= '0;
    end else if (w_clear) begin
      r_pkts_total    <= '0;
      r_pkts_zeroed   <= '0;
      r_pkts_bypassed <= '0;
    end else if (w_accept && s_axis_tlast) begin
      r_pkts_total <= r_pkts_total + 32'd1;
      if (w_count_zeroed) r_pkts_zeroed   <= r_pkts_zeroed + 32'd1;
      else                r_pkts_bypassed <= r_pkts_bypassed + 32'd1;
    end
  end

  assign ro_regs = {r_pkts_bypassed, r_pkts_zeroed, r_pkts_total};

  axis_reg_slice #(
    .DATA_WIDTH (C_M_AXIS_DATA_WIDTH),
    .USER_WIDTH (C_M_AXIS_TUSER_WIDTH)
  ) u_slice (
    .i_clk      (axi_aclk),
    .i_rst_n    (axi_aresetn),
    .i_s_tdata  (w_tdata),
    .i_s_tstrb  (s_axis_tstrb),
    .i_s_tuser  (s_axis_tuser),
    .i_s_tlast  (s_axis_tlast),
    .i_s_tvalid (s_axis_tvalid),
    .o_s_tready (s_axis_tready),
    .o_m_tdata  (m_axis_tdata),
    .o_m_tstrb  (m_axis_tstrb),
    .o_m_tuser  (m_axis_tuser),
    .o_m_tlast  (m_axis_tlast),
    .o_m_tvalid (m_axis_tvalid),
    .i_m_tready (m_axis_tready)
  );

endmodule

// File: tb/tb_udp_csum_zero.sv
// Directed bench for udp_csum_zero.
module tb_udp_csum_zero;

  logic          axi_aclk = 1'b0;
  logic          axi_aresetn;
  logic [255:0]  s_axis_tdata;
  logic [31:0]   s_axis_tstrb;
  logic [127:0]  s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [255:0]  m_axis_tdata;
  logic [31:0]   m_axis_tstrb;
  logic [127:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [31:0]   rw_regs;
  logic [31:0]   rw_defaults;
  logic [95:0]   ro_regs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 axi_aclk = ~axi_aclk;

  udp_csum_zero #(
    .C_M_AXIS_DATA_WIDTH  (256),
    .C_S_AXIS_DATA_WIDTH  (256),
    .C_M_AXIS_TUSER_WIDTH (128),
    .C_S_AXIS_TUSER_WIDTH (128),
    .C_S_AXI_DATA_WIDTH   (32),
    .NUM_RW_REGS          (1),
    .NUM_RO_REGS          (3)
  ) dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .rw_regs       (rw_regs),
    .rw_defaults   (rw_defaults),
    .ro_regs       (ro_regs)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] fill(input logic [31:0] seed);
    return {8{seed}};
  endfunction

  function automatic logic [255:0] mkhdr(input logic [15:0] et, input logic [7:0] vihl,
                                         input logic [15:0] frag, input logic [7:0] proto);
    logic [255:0] h;
    h = fill(32'h1122_3344);
    h[159:144] = et;
    h[143:136] = vihl;
    h[95:80]   = frag;
    h[71:64]   = proto;
    return h;
  endfunction

  function automatic logic [255:0] beat2(input logic patched);
    logic [255:0] b;
    b = fill(32'h5566_7788);
    b[191:176] = patched ? 16'h0000 : 16'hA1B2;
    return b;
  endfunction

  // Drive one beat (downstream assumed ready), then check it one edge later.
  task automatic beat(input string tag, input logic [255:0] d, input logic [31:0] strb,
                      input logic last, input logic [255:0] exp);
    int n = 0;
    logic [127:0] u;
    u = d[255:128] ^ 128'h5A5A_0F0F_C3C3_9696_1234_5678_9ABC_DEF0;
    s_axis_tdata  = d;
    s_axis_tstrb  = strb;
    s_axis_tuser  = u;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 50) begin
      @(negedge axi_aclk);
      n++;
    end
    check({tag, " s_tready"}, s_axis_tready, 1'b1);
    @(posedge axi_aclk);
    #1;
    s_axis_tvalid = 1'b0;
    check({tag, " valid"}, m_axis_tvalid, 1'b1);
    check({tag, " data"},  m_axis_tdata,  exp);
    check({tag, " strb"},  m_axis_tstrb,  strb);
    check({tag, " user"},  m_axis_tuser,  u);
    check({tag, " last"},  m_axis_tlast,  last);
  endtask

  task automatic send3(input string tag, input logic [255:0] h, input logic patched);
    beat({tag, " b1"}, h, 32'hFFFF_FFFF, 1'b0, h);
    beat({tag, " b2"}, beat2(1'b0), 32'hFFFF_FFFF, 1'b0, beat2(patched));
    beat({tag, " b3"}, fill(32'h99AA_BBCC), 32'hFFFF_F000, 1'b1, fill(32'h99AA_BBCC));
  endtask

  task automatic send2(input string tag, input logic [255:0] h, input logic [31:0] strb2,
                       input logic patched);
    beat({tag, " b1"}, h, 32'hFFFF_FFFF, 1'b0, h);
    beat({tag, " b2"}, beat2(1'b0), strb2, 1'b1, beat2(patched));
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] t, input logic [31:0] z,
                           input logic [31:0] b);
    check({tag, " pkts_total"},    ro_regs[31:0],  t);
    check({tag, " pkts_zeroed"},   ro_regs[63:32], z);
    check({tag, " pkts_bypassed"}, ro_regs[95:64], b);
  endtask

  task automatic clear_counters();
    @(negedge axi_aclk);
    rw_regs[1] = 1'b1;
    @(negedge axi_aclk);
    rw_regs[1] = 1'b0;
  endtask

  logic [255:0] hudp;
  logic [255:0] bp_in  [3];
  logic [255:0] bp_exp [3];
  logic [3:0]   pat;
  logic         held;
  logic [255:0] held_d;
  logic         acc;
  int           in_idx;
  int           out_idx;

  initial begin
    axi_aresetn   = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    rw_regs       = 32'h1;
    hudp = mkhdr(16'h0800, 8'h45, 16'h4000, 8'd17);

    // Reset state
    repeat (3) @(negedge axi_aclk);
    check("rst m_tvalid", m_axis_tvalid, 1'b0);
    check("rst m_tdata",  m_axis_tdata,  '0);
    check("rst m_tstrb",  m_axis_tstrb,  '0);
    check("rst m_tuser",  m_axis_tuser,  '0);
    check("rst m_tlast",  m_axis_tlast,  1'b0);
    check("rst ro_regs",  ro_regs,       '0);
    check("rw_defaults",  rw_defaults,   32'h0000_0001);
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    check("idle s_tready", s_axis_tready, 1'b1);

    // UDP zeroed
    send3("udp", hudp, 1'b1);
    check_cnt("udp", 1, 1, 0);

    // Non-UDP bypassed: TCP and ARP
    clear_counters();
    send3("tcp", mkhdr(16'h0800, 8'h45, 16'h4000, 8'd6), 1'b0);
    send2("arp", mkhdr(16'h0806, 8'h45, 16'h4000, 8'd17), 32'hFFFF_FFFF, 1'b0);
    check_cnt("nonudp", 2, 0, 2);

    // Backpressure: m_axis_tready 1,0,0,1 repeating
    clear_counters();
    bp_in[0]  = hudp;
    bp_in[1]  = beat2(1'b0);
    bp_in[2]  = fill(32'h99AA_BBCC);
    bp_exp[0] = hudp;
    bp_exp[1] = beat2(1'b1);
    bp_exp[2] = fill(32'h99AA_BBCC);
    pat = 4'b1001;
    held = 1'b0;
    held_d = '0;
    in_idx = 0;
    out_idx = 0;
    for (int cyc = 0; cyc < 40 && out_idx < 3; cyc++) begin
      @(negedge axi_aclk);
      m_axis_tready = pat[cyc % 4];
      if (in_idx < 3) begin
        s_axis_tdata  = bp_in[in_idx];
        s_axis_tstrb  = 32'hFFFF_FFFF;
        s_axis_tuser  = 128'h0BAD_CAFE;
        s_axis_tlast  = (in_idx == 2);
        s_axis_tvalid = 1'b1;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      #1;
      check("bp ready rule", s_axis_tready, !m_axis_tvalid || m_axis_tready);
      if (held) check("bp hold data", m_axis_tdata, held_d);
      held   = m_axis_tvalid && !m_axis_tready;
      held_d = m_axis_tdata;
      if (m_axis_tvalid && m_axis_tready) begin
        check("bp out data", m_axis_tdata, bp_exp[out_idx]);
        check("bp out last", m_axis_tlast, out_idx == 2);
        out_idx++;
      end
      acc = s_axis_tvalid && s_axis_tready;
      @(posedge axi_aclk);
      if (acc) in_idx++;
    end
    #1;
    s_axis_tvalid = 1'b0;
    check("bp beats out", out_idx, 3);
    @(negedge axi_aclk);
    m_axis_tready = 1'b1;
    @(negedge axi_aclk);
    check("bp no duplicate", m_axis_tvalid, 1'b0);
    check_cnt("bp", 1, 1, 0);

    // Boundary cases
    clear_counters();
    send3("ihl6", mkhdr(16'h0800, 8'h46, 16'h4000, 8'd17), 1'b0);
    send3("frag", mkhdr(16'h0800, 8'h45, 16'h0010, 8'd17), 1'b0);
    send2("strb", hudp, 32'hFF00_0000, 1'b0);
    beat("single", hudp, 32'hFFFF_FFFF, 1'b1, hudp);
    send2("after single", hudp, 32'hFFFF_FFFF, 1'b1);
    check_cnt("boundary", 5, 1, 4);

    // Enable control, including changes mid-packet
    clear_counters();
    rw_regs = 32'h0;
    send2("en0", hudp, 32'hFFFF_FFFF, 1'b0);
    beat("en01 b1", hudp, 32'hFFFF_FFFF, 1'b0, hudp);
    rw_regs = 32'h1;
    beat("en01 b2", beat2(1'b0), 32'hFFFF_FFFF, 1'b1, beat2(1'b1));
    beat("en10 b1", hudp, 32'hFFFF_FFFF, 1'b0, hudp);
    rw_regs = 32'h0;
    beat("en10 b2", beat2(1'b0), 32'hFFFF_FFFF, 1'b1, beat2(1'b0));
    rw_regs = 32'h1;
    check_cnt("enable", 3, 1, 2);

    // Clear held across a tlast beat
    rw_regs = 32'h3;
    beat("clr pkt", hudp, 32'hFFFF_FFFF, 1'b1, hudp);
    check_cnt("clr on tlast", 0, 0, 0);
    @(negedge axi_aclk);
    check_cnt("clr held", 0, 0, 0);
    rw_regs = 32'h1;

    // Counter wrap from a preloaded FFFF_FFFF
    @(negedge axi_aclk);
    force dut.r_pkts_total = 32'hFFFF_FFFF;
    @(posedge axi_aclk);
    #1;
    release dut.r_pkts_total;
    @(negedge axi_aclk);
    check("preload total", ro_regs[31:0], 32'hFFFF_FFFF);
    beat("wrap pkt", hudp, 32'hFFFF_FFFF, 1'b1, hudp);
    check_cnt("wrap", 0, 0, 1);

    // Reset after beat 2 of a 4-beat packet
    beat("rst b1", hudp, 32'hFFFF_FFFF, 1'b0, hudp);
    beat("rst b2", beat2(1'b0), 32'hFFFF_FFFF, 1'b0, beat2(1'b1));
    axi_aresetn = 1'b0;
    #1;
    check("rst mid m_tvalid", m_axis_tvalid, 1'b0);
    check("rst mid m_tdata",  m_axis_tdata,  '0);
    @(negedge axi_aclk);
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    check_cnt("rst mid", 0, 0, 0);
    @(negedge axi_aclk);
    send3("post rst", hudp, 1'b1);
    check_cnt("post rst", 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
